seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//   Parametrised multi-cycle add/subtract unit that succeeds the single-bit full adder.
//   Adds two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, through one shared
//   CHUNK-bit ripple adder, so area stays small for wide datapaths.
//   Sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath.
//   Adds a subtract-with-borrow mode and a signed-overflow flag.
// PARAMETERS
//   WIDTH  32  operand and result width in bits; must be an integer multiple of CHUNK
//   CHUNK   8  bits processed per cycle; NCH = WIDTH/CHUNK cycles per operation
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      unit can accept an operand bundle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode) or borrow-in (sub mode)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of the MSB; in sub mode 1 means no borrow
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk counter=0.
//     A reset asserted in any state, including mid-BUSY, aborts the operation with these values.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1.
//     - On in_valid&&in_ready: latch a, b_eff = sub ? ~b : b, and carry = cin ^ sub.
//     - Clear the counter and go to BUSY.
//   - BUSY: in_ready=0. Each cycle, chunk k (bits k*CHUNK +: CHUNK) of a and b_eff passes
//     through the chunk adder with the running carry.
//     - The result chunk is written into sum[k*CHUNK +: CHUNK] and the carry register updated.
//     - k increments each cycle. On k==NCH-1, capture cout and ovf, then go to DONE.
//   - DONE: out_valid=1, in_ready=0.
//     - sum, cout and ovf are held stable until out_valid&&out_ready, then go to IDLE.
//     - The next bundle is accepted no earlier than the cycle after that handshake
//       (no same-cycle turnaround).
//   - Latency: accept at edge T; out_valid is high after edge T+NCH, i.e. NCH cycles.
//     Peak throughput is one result per NCH+2 cycles.
//   - in_valid and operand inputs are ignored outside IDLE; the latched copies are used.
//   - sum may show partial chunks during BUSY; it is only meaningful while out_valid=1.
//   - NCH==1 (CHUNK==WIDTH): BUSY lasts one cycle, latency 1.
//   - WIDTH%CHUNK != 0, or CHUNK<1: elaboration-time error (generate-time $error).
//   - Arithmetic: pure modulo-2^WIDTH. No saturation. Flags valid only in DONE.
// STRUCTURE
//   - Package adder_pkg:
//     - state typedef enum {IDLE, BUSY, DONE};
//     - function nch(WIDTH, CHUNK) returning the chunk count;
//     - localparam for the counter width, $clog2(NCH) with a minimum of 1.
//   - Sub-module fa_chunk #(CHUNK): combinational ripple of CHUNK full adders.
//     Ports a, b, ci, s, co, c_msb (carry into the top bit, used for ovf).
//   - Top level: FSM, chunk counter, operand/result registers, chunk mux/demux.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//   1. Add: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0
//      -> sum=0x0000_0000, cout=1, ovf=0; out_valid rises exactly 4 cycles after acceptance.
//   2. Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0
//      -> sum=0x8000_0000, cout=0, ovf=1.
//   3. Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
//      Then a=7, b=5, cin=1 -> sum=1, cout=1.
//   4. Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and operands
//      -> sum, cout, ovf stable; in_ready=0; nothing new accepted; result consumed on release.
//   5. Reset mid-op: assert rst for 1 cycle while k==2
//      -> next cycle out_valid=0, in_ready=1, sum=0. A fresh op afterwards completes correctly.
//   6. WIDTH=CHUNK=4: exhaustive a, b, cin, sub (1024 cases) against a behavioural model
//      -> all sum/cout/ovf match; latency 1 cycle each.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked add/subtract unit.
package adder_pkg;

    // Controller states: waiting for operands, stepping through chunks, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // Number of chunk cycles per operation; a zero chunk size yields zero so that an
    // illegal parameter set reaches the elaboration check instead of dividing by zero
    function automatic int nch(input int width, input int chunk);
        return (chunk < 1) ? 0 : width / chunk;
    endfunction

    // Chunk counter width, never narrower than one bit even for a single chunk
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational ripple of CHUNK full adders; also exposes the carry into the top bit
// so the caller can form the signed-overflow flag.
module fa_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic rippleCarry;

    // Walk the carry from bit 0 upwards, recording the carry entering the top bit
    always_comb begin
        s           = '0;
        c_msb       = 1'b0;
        rippleCarry = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = rippleCarry;
            end
            s[i]        = a[i] ^ b[i] ^ rippleCarry;
            rippleCarry = (a[i] & b[i]) | (rippleCarry & (a[i] ^ b[i]));
        end
        co = rippleCarry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed CHUNK bits per cycle,
// least significant chunk first, through one shared fa_chunk instance.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = nch(WIDTH, CHUNK);
    localparam int CNT_W = cntWidth(NCH);

    // Reject parameter sets that cannot be split into whole chunks
    generate
        if (CHUNK < 1) begin : gBadChunk
            $error("seq_chunk_adder: CHUNK must be at least 1");
        end else if (WIDTH % CHUNK != 0) begin : gBadWidth
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             carryReg;
    logic [WIDTH-1:0] sumReg;
    logic             coutReg;
    logic             ovfReg;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] sChunk;
    logic             chunkCo;
    logic             chunkCMsb;
    logic             lastChunk;

    assign lastChunk = (cnt == CNT_W'(NCH - 1));
    assign aChunk    = aReg[cnt * CHUNK +: CHUNK];
    assign bChunk    = bReg[cnt * CHUNK +: CHUNK];

    fa_chunk #(
        .CHUNK(CHUNK)
    ) uChunk (
        .a    (aChunk),
        .b    (bChunk),
        .ci   (carryReg),
        .s    (sChunk),
        .co   (chunkCo),
        .c_msb(chunkCMsb)
    );

    // State register; reset drops any operation in flight back to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: accept in IDLE, step until the last chunk, hold until the consumer takes it
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid)  nextState = BUSY;
            BUSY:    if (lastChunk) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs depend on the state alone, so DONE never turns straight around
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch operands (inverting b for subtract), then fold one chunk per cycle
    // into the result, capturing the final carry and overflow on the last chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            aReg     <= '0;
            bReg     <= '0;
            carryReg <= 1'b0;
            sumReg   <= '0;
            coutReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aReg     <= a;
                        bReg     <= sub ? ~b : b;
                        carryReg <= cin ^ sub;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    sumReg[cnt * CHUNK +: CHUNK] <= sChunk;
                    carryReg                     <= chunkCo;
                    cnt                          <= cnt + CNT_W'(1);
                    if (lastChunk) begin
                        coutReg <= chunkCo;
                        ovfReg  <= chunkCo ^ chunkCMsb;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sumReg;
    assign cout = coutReg;
    assign ovf  = ovfReg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: a 32/8 instance runs directed vectors and a 4/4 instance runs an
// exhaustive sweep; expected results are queued at issue and checked by monitors.
module tb_seq_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          lat;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        qBig[$];
    exp_t        qSmall[$];

    logic        rstBig = 1'b1;
    logic        inValidBig = 1'b0;
    logic        inReadyBig;
    logic [31:0] aBig = '0;
    logic [31:0] bBig = '0;
    logic        cinBig = 1'b0;
    logic        subBig = 1'b0;
    logic        outValidBig;
    logic        outReadyBig = 1'b1;
    logic [31:0] sumBig;
    logic        coutBig;
    logic        ovfBig;

    logic        rstSmall = 1'b1;
    logic        inValidSmall = 1'b0;
    logic        inReadySmall;
    logic [3:0]  aSmall = '0;
    logic [3:0]  bSmall = '0;
    logic        cinSmall = 1'b0;
    logic        subSmall = 1'b0;
    logic        outValidSmall;
    logic        outReadySmall = 1'b1;
    logic [3:0]  sumSmall;
    logic        coutSmall;
    logic        ovfSmall;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dutBig (
        .clk(clk), .rst(rstBig), .in_valid(inValidBig), .in_ready(inReadyBig),
        .a(aBig), .b(bBig), .cin(cinBig), .sub(subBig),
        .out_valid(outValidBig), .out_ready(outReadyBig),
        .sum(sumBig), .cout(coutBig), .ovf(ovfBig)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dutSmall (
        .clk(clk), .rst(rstSmall), .in_valid(inValidSmall), .in_ready(inReadySmall),
        .a(aSmall), .b(bSmall), .cin(cinSmall), .sub(subSmall),
        .out_valid(outValidSmall), .out_ready(outReadySmall),
        .sum(sumSmall), .cout(coutSmall), .ovf(ovfSmall)
    );

    // One counted comparison; any mismatch (including X) is reported with both values
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", name);
    endtask

    // Monitor for the wide instance: latency on out_valid rising, result on handshake
    int  negBig = 0;
    int  acceptBig = 0;
    logic prevOvBig = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        negBig++;
        if (rstBig) begin
            prevOvBig = 1'b0;
        end else begin
            if (inValidBig && inReadyBig) acceptBig = negBig;
            if (outValidBig && !prevOvBig && qBig.size() != 0)
                checkOutput({qBig[0].tag, "_latency"}, 32'(negBig - acceptBig - 1), 32'(qBig[0].lat));
            if (outValidBig && outReadyBig) begin
                if (qBig.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL big_unexpected_output: got sum 0x%0h, expected no result", sumBig);
                end else begin
                    e = qBig.pop_front();
                    checkOutput({e.tag, "_sum"},  sumBig, e.sum);
                    checkOutput({e.tag, "_cout"}, 32'(coutBig), 32'(e.cout));
                    checkOutput({e.tag, "_ovf"},  32'(ovfBig), 32'(e.ovf));
                end
            end
            prevOvBig = outValidBig;
        end
    end

    // Monitor for the narrow instance, same scheme
    int  negSmall = 0;
    int  acceptSmall = 0;
    logic prevOvSmall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        negSmall++;
        if (rstSmall) begin
            prevOvSmall = 1'b0;
        end else begin
            if (inValidSmall && inReadySmall) acceptSmall = negSmall;
            if (outValidSmall && !prevOvSmall && qSmall.size() != 0)
                checkOutput({qSmall[0].tag, "_latency"}, 32'(negSmall - acceptSmall - 1), 32'(qSmall[0].lat));
            if (outValidSmall && outReadySmall) begin
                if (qSmall.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL small_unexpected_output: got sum 0x%0h, expected no result", sumSmall);
                end else begin
                    e = qSmall.pop_front();
                    checkOutput({e.tag, "_sum"},  32'(sumSmall), e.sum);
                    checkOutput({e.tag, "_cout"}, 32'(coutSmall), 32'(e.cout));
                    checkOutput({e.tag, "_ovf"},  32'(ovfSmall), 32'(e.ovf));
                end
            end
            prevOvSmall = outValidSmall;
        end
    end

    // Queue the hand-computed result, then present the operands until accepted
    task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb,
                                 input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        e.sum = es; e.cout = ec; e.ovf = eo; e.lat = 4; e.tag = tag;
        qBig.push_back(e);
        n = 0;
        while (!inReadyBig && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReadyBig) reportTimeout({tag, "_in_ready"});
        aBig = av; bBig = bv; cinBig = ci; subBig = sb; inValidBig = 1'b1;
        @(posedge clk); #1;
        inValidBig = 1'b0;
    endtask

    // Narrow instance: expected values from plain integer arithmetic
    task automatic applyStimulusSmall(input int idx, input logic [3:0] av, input logic [3:0] bv,
                                      input logic ci, input logic sb);
        exp_t e;
        int   ua, ub, sa, sbv, uRes, sRes, n;
        ua = av; ub = bv; sa = $signed(av); sbv = $signed(bv);
        if (sb) begin
            uRes   = ua - ub - int'(ci);
            sRes   = sa - sbv - int'(ci);
            e.cout = (ua >= ub + int'(ci));
        end else begin
            uRes   = ua + ub + int'(ci);
            sRes   = sa + sbv + int'(ci);
            e.cout = (uRes > 15);
        end
        e.sum = 32'(uRes[3:0]);
        e.ovf = (sRes > 7) || (sRes < -8);
        e.lat = 1;
        e.tag = $sformatf("w4_%0d", idx);
        qSmall.push_back(e);
        n = 0;
        while (!inReadySmall && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReadySmall) reportTimeout({e.tag, "_in_ready"});
        aSmall = av; bSmall = bv; cinSmall = ci; subSmall = sb; inValidSmall = 1'b1;
        @(posedge clk); #1;
        inValidSmall = 1'b0;
    endtask

    task automatic drainBig(input string name);
        int n = 0;
        while (qBig.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (qBig.size() != 0) begin
            reportTimeout(name);
            qBig.delete();
        end
    endtask

    // Directed sequence on the wide instance
    task automatic runBig();
        int n;
        repeat (2) @(posedge clk);
        #1 rstBig = 1'b0;
        checkOutput("reset_in_ready", 32'(inReadyBig), 32'd1);
        checkOutput("reset_out_valid", 32'(outValidBig), 32'd0);
        checkOutput("reset_sum", sumBig, 32'd0);
        checkOutput("reset_cout", 32'(coutBig), 32'd0);
        checkOutput("reset_ovf", 32'(ovfBig), 32'd0);

        applyStimulus("add_wrap",  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus("sub_neg",   32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("sub_brw",   32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus("sub_ovf",   32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        applyStimulus("add_cin",   32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        applyStimulus("add_chain", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
        applyStimulus("add_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drainBig("directed_drain");

        outReadyBig = 1'b0;
        applyStimulus("backpress", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n = 0;
        while (!outValidBig && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!outValidBig) reportTimeout("bp_out_valid");
        for (int i = 0; i < 3; i++) begin
            inValidBig = ~inValidBig;
            aBig = $urandom; bBig = $urandom;
            cinBig = ~cinBig; subBig = ~subBig;
            @(posedge clk); #1;
            checkOutput("bp_hold_sum", sumBig, 32'hFFFF_FFFF);
            checkOutput("bp_hold_cout", 32'(coutBig), 32'd0);
            checkOutput("bp_hold_ovf", 32'(ovfBig), 32'd0);
            checkOutput("bp_hold_in_ready", 32'(inReadyBig), 32'd0);
            checkOutput("bp_hold_out_valid", 32'(outValidBig), 32'd1);
        end
        inValidBig = 1'b0;
        outReadyBig = 1'b1;
        drainBig("bp_drain");
        @(posedge clk); #1;
        checkOutput("bp_after_in_ready", 32'(inReadyBig), 32'd1);
        checkOutput("bp_after_out_valid", 32'(outValidBig), 32'd0);

        applyStimulus("abort", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstBig = 1'b1;
        qBig.delete();
        @(posedge clk); #1;
        rstBig = 1'b0;
        checkOutput("abort_out_valid", 32'(outValidBig), 32'd0);
        checkOutput("abort_in_ready", 32'(inReadyBig), 32'd1);
        checkOutput("abort_sum", sumBig, 32'd0);
        applyStimulus("post_abort", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
        drainBig("post_abort_drain");
        repeat (6) @(posedge clk);
        #1 checkOutput("final_in_ready", 32'(inReadyBig), 32'd1);
    endtask

    // Exhaustive sweep on the single-chunk instance
    task automatic runSmall();
        int n;
        repeat (2) @(posedge clk);
        #1 rstSmall = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            applyStimulusSmall(i, i[3:0], i[7:4], i[8], i[9]);
        end
        n = 0;
        while (qSmall.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (qSmall.size() != 0) begin
            reportTimeout("w4_drain");
            qSmall.delete();
        end
    endtask

    // Run both instances side by side, then summarise
    initial begin
        $display("[TB] starting seq_chunk_adder bench");
        fork
            runBig();
            runSmall();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if something wedges beyond every bounded wait
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
